call_frame_ctrl: RTL and testbench

Controller that sequences the operand stack (SuperStack) for WebAssembly-style call frames. It owns the stack's op, data and underflow_limit inputs. It muxes a host op channel with multi-cycle CALL/RETURN sequences, and keeps an internal frame stack of saved underflow limits. It sits between the instruction decoder and SuperStack; all stack ops and status codes use the stack.vh encodings.

---
 rtl/call_frame_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_call_frame_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/call_frame_ctrl.sv
// Call-frame sequencer for a SuperStack operand stack: passes host ops through while idle and
// runs CALL/RETURN sequences that save and restore the stack's underflow limit (frame base).
module call_frame_ctrl #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 7,
   parameter int unsigned FRAMES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        usr_op,
   input  logic [WIDTH-1:0]  usr_data,
   output logic              usr_ready,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd,
   output logic              cmd_ready,
   input  logic [DEPTH:0]    nargs,
   input  logic [WIDTH-1:0]  ret_val,
   output logic              done,
   output logic              err,
   output logic [2:0]        err_code,
   output logic [FRAMES:0]   frame_level,
   output logic [2:0]        stk_op,
   output logic [WIDTH-1:0]  stk_data,
   output logic [DEPTH:0]    stk_underflow_limit,
   input  logic [DEPTH:0]    stk_index,
   input  logic [2:0]        stk_status
);

   // Stack op encodings
   localparam logic [2:0] OpNone           = 3'd0;
   localparam logic [2:0] OpUnderflowReset = 3'd4;
   localparam logic [2:0] OpUnderflowPush  = 3'd5;

   // Stack status encodings
   localparam logic [2:0] StatusOverflow  = 3'd3;
   localparam logic [2:0] StatusUnderflow = 3'd4;
   localparam logic [2:0] StatusUnkownOp  = 3'd5;

   localparam logic [1:0] CmdCall   = 2'd0;
   localparam logic [1:0] CmdRetVal = 2'd2;
   localparam logic [1:0] CmdRsvd   = 2'd3;

   localparam logic [2:0] ErrNone     = 3'd0;
   localparam logic [2:0] ErrArgs     = 3'd1;
   localparam logic [2:0] ErrFrameOvf = 3'd2;
   localparam logic [2:0] ErrFrameUnf = 3'd3;
   localparam logic [2:0] ErrStack    = 3'd4;
   localparam logic [2:0] ErrBadCmd   = 3'd5;

   localparam logic [FRAMES:0] MaxLevel = {1'b1, {FRAMES{1'b0}}};

   typedef enum logic [2:0] {
      StIdle,
      StDrop,
      StRestore,
      StSettle,
      StDone
   } state_e;

   state_e             state_q;
   logic [DEPTH:0]     limit_q;
   logic [FRAMES:0]    level_q;
   logic [WIDTH-1:0]   ret_val_q;
   logic               ret_is_val_q;
   logic               sticky_q;
   logic               err_pulse_q;
   logic [2:0]         err_code_q;
   logic [DEPTH:0]     frame_mem [1 << FRAMES];

   logic               accept;
   logic [2:0]         acc_code;
   logic [DEPTH+1:0]   need;
   logic               args_short;
   logic               stack_bad;
   logic               done_err;
   logic [FRAMES:0]    level_inc;
   logic [FRAMES:0]    level_dec;
   logic [FRAMES-1:0]  wr_idx;
   logic [FRAMES-1:0]  rd_idx;
   logic               call_ok;

   assign usr_ready = (state_q == StIdle);
   assign cmd_ready = usr_ready && (usr_op == OpNone);
   assign accept    = cmd_valid && cmd_ready;

   // Extra bit so limit + nargs cannot wrap past the index range
   assign need       = {1'b0, limit_q} + {1'b0, nargs};
   assign args_short = ({1'b0, stk_index} < need);

   assign stack_bad = (stk_status == StatusOverflow) || (stk_status == StatusUnderflow) ||
                      (stk_status == StatusUnkownOp);

   assign level_inc = level_q + 1'b1;
   assign level_dec = level_q - 1'b1;
   assign wr_idx    = level_q[FRAMES-1:0];
   assign rd_idx    = level_dec[FRAMES-1:0];

   always_comb begin
      acc_code = ErrNone;
      if (cmd == CmdRsvd) begin
         acc_code = ErrBadCmd;
      end else if (cmd == CmdCall && level_q == MaxLevel) begin
         acc_code = ErrFrameOvf;
      end else if (cmd == CmdCall && args_short) begin
         acc_code = ErrArgs;
      end else if (cmd != CmdCall && level_q == '0) begin
         acc_code = ErrFrameUnf;
      end
   end

   assign call_ok = accept && (acc_code == ErrNone) && (cmd == CmdCall);

   always_comb begin
      stk_op   = OpNone;
      stk_data = '0;
      unique case (state_q)
         StIdle: begin
            stk_op   = usr_op;
            stk_data = usr_data;
         end
         StDrop: begin
            stk_op   = ret_is_val_q ? OpUnderflowPush : OpUnderflowReset;
            stk_data = ret_val_q;
         end
         default: begin
            stk_op   = OpNone;
            stk_data = '0;
         end
      endcase
   end

   // Sequence completion reads the status produced by the SETTLE op in the same cycle
   assign done_err            = sticky_q || stack_bad;
   assign done                = err_pulse_q || (state_q == StDone);
   assign err                 = err_pulse_q || ((state_q == StDone) && done_err);
   assign err_code            = (state_q == StDone) ? (done_err ? ErrStack : ErrNone) : err_code_q;
   assign frame_level         = level_q;
   assign stk_underflow_limit = limit_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         limit_q      <= '0;
         level_q      <= '0;
         ret_val_q    <= '0;
         ret_is_val_q <= 1'b0;
         sticky_q     <= 1'b0;
         err_pulse_q  <= 1'b0;
         err_code_q   <= ErrNone;
      end else begin
         err_pulse_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  if (acc_code != ErrNone) begin
                     err_pulse_q <= 1'b1;
                     err_code_q  <= acc_code;
                  end else if (cmd == CmdCall) begin
                     limit_q <= stk_index - nargs;
                     level_q <= level_inc;
                     state_q <= StSettle;
                  end else begin
                     ret_val_q    <= ret_val;
                     ret_is_val_q <= (cmd == CmdRetVal);
                     state_q      <= StDrop;
                  end
               end
            end
            StDrop: begin
               state_q <= StRestore;
            end
            StRestore: begin
               if (stack_bad) begin
                  sticky_q <= 1'b1;
               end
               limit_q <= frame_mem[rd_idx];
               level_q <= level_dec;
               state_q <= StSettle;
            end
            StSettle: begin
               state_q <= StDone;
            end
            StDone: begin
               err_code_q <= done_err ? ErrStack : ErrNone;
               sticky_q   <= 1'b0;
               state_q    <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Frame memory is deliberately left uninitialised by reset
   always_ff @(posedge clk) begin
      if (!reset && call_ok) begin
         frame_mem[wr_idx] <= limit_q;
      end
   end

endmodule

// File: tb/tb_call_frame_ctrl.sv
// Bench for call_frame_ctrl: a small SuperStack model drives index/status back into the DUT, and
// a queue-based frame/stack reference model predicts every command outcome.
module tb_call_frame_ctrl;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned FRAMES = 2;
   localparam int SMAX = 1 << DEPTH;
   localparam int MAXF = 1 << FRAMES;

   localparam logic [2:0] OpNone = 3'd0, OpPush = 3'd1, OpPop = 3'd2, OpReplace = 3'd3;
   localparam logic [2:0] OpUReset = 3'd4, OpUPush = 3'd5;
   localparam logic [2:0] StNone = 3'd0, StEmpty = 3'd1, StFull = 3'd2;
   localparam logic [2:0] StOverflow = 3'd3, StUnderflow = 3'd4, StUnknown = 3'd5;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [2:0]        usr_op = OpNone;
   logic [WIDTH-1:0]  usr_data = '0;
   logic              usr_ready;
   logic              cmd_valid = 1'b0;
   logic [1:0]        cmd = '0;
   logic              cmd_ready;
   logic [DEPTH:0]    nargs = '0;
   logic [WIDTH-1:0]  ret_val = '0;
   logic              done;
   logic              err;
   logic [2:0]        err_code;
   logic [FRAMES:0]   frame_level;
   logic [2:0]        stk_op;
   logic [WIDTH-1:0]  stk_data;
   logic [DEPTH:0]    stk_underflow_limit;
   logic [DEPTH:0]    stk_index;
   logic [2:0]        stk_status;

   int n_tests = 0;
   int n_fail  = 0;

   call_frame_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
      .clk                 (clk),
      .reset               (reset),
      .usr_op              (usr_op),
      .usr_data            (usr_data),
      .usr_ready           (usr_ready),
      .cmd_valid           (cmd_valid),
      .cmd                 (cmd),
      .cmd_ready           (cmd_ready),
      .nargs               (nargs),
      .ret_val             (ret_val),
      .done                (done),
      .err                 (err),
      .err_code            (err_code),
      .frame_level         (frame_level),
      .stk_op              (stk_op),
      .stk_data            (stk_data),
      .stk_underflow_limit (stk_underflow_limit),
      .stk_index           (stk_index),
      .stk_status          (stk_status)
   );

   always #5 clk = ~clk;

   // ---------------- SuperStack model ----------------
   typedef struct packed {
      logic [DEPTH:0]   idx;
      logic [2:0]       status;
      logic             we;
      logic [DEPTH-1:0] waddr;
   } step_t;

   function automatic step_t stack_step(input logic [2:0] op, input logic [DEPTH:0] idx,
                                        input logic [DEPTH:0] lim);
      step_t r;
      logic  bad;
      r.idx = idx; r.status = StNone; r.we = 1'b0; r.waddr = idx[DEPTH-1:0]; bad = 1'b0;
      case (op)
         OpNone: ;
         OpPush:    if (idx == SMAX) begin bad = 1'b1; r.status = StOverflow; end
                    else begin r.we = 1'b1; r.waddr = idx[DEPTH-1:0]; r.idx = idx + 1'b1; end
         OpPop:     if (idx <= lim) begin bad = 1'b1; r.status = StUnderflow; end
                    else r.idx = idx - 1'b1;
         OpReplace: if (idx <= lim) begin bad = 1'b1; r.status = StUnderflow; end
                    else begin r.we = 1'b1; r.waddr = 4'(idx - 1'b1); end
         OpUReset:  r.idx = lim;
         OpUPush:   if (lim == SMAX) begin bad = 1'b1; r.status = StOverflow; end
                    else begin r.we = 1'b1; r.waddr = lim[DEPTH-1:0]; r.idx = lim + 1'b1; end
         default:   begin bad = 1'b1; r.status = StUnknown; end
      endcase
      if (!bad) r.status = (r.idx == lim) ? StEmpty : (r.idx == SMAX) ? StFull : StNone;
      return r;
   endfunction

   logic [DEPTH:0]   s_idx;
   logic [2:0]       s_status;
   logic [WIDTH-1:0] s_mem [SMAX];
   step_t            s_nx;

   assign s_nx       = stack_step(stk_op, s_idx, stk_underflow_limit);
   assign stk_index  = s_idx;
   assign stk_status = s_status;

   always @(posedge clk) begin
      if (reset) begin
         s_idx    <= '0;
         s_status <= StEmpty;
      end else begin
         s_idx    <= s_nx.idx;
         s_status <= s_nx.status;
         if (s_nx.we) s_mem[s_nx.waddr] <= stk_data;
      end
   end

   // ---------------- Reference model ----------------
   logic [WIDTH-1:0] ref_stk [$];
   int               ref_saved [$];
   int               ref_limit;

   function automatic logic [2:0] exp_status(input int sz, input int lim);
      if (sz == lim) return StEmpty;
      if (sz == SMAX) return StFull;
      return StNone;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; usr_op = OpNone; cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      ref_stk.delete(); ref_saved.delete(); ref_limit = 0;
   endtask

   task automatic host_op(input logic [2:0] op, input logic [WIDTH-1:0] data);
      usr_op = op; usr_data = data;
      cmd_valid = (op != OpNone) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd = 2'($urandom_range(0, 3));
      #1;
      check_eq("host_stk_op", stk_op, op);
      check_eq("host_stk_data", stk_data, data);
      check_eq("host_cmd_ready", cmd_ready, op == OpNone);
      @(posedge clk); #1;
      usr_op = OpNone; cmd_valid = 1'b0;
      if (op == OpPush) ref_stk.push_back(data);
      if (op == OpPop) void'(ref_stk.pop_back());
      check_eq("host_done", done, 0);
      check_eq("host_index", stk_index, ref_stk.size());
      check_eq("host_level", frame_level, ref_saved.size());
   endtask

   task automatic do_cmd(input logic [1:0] c, input int n, input logic [WIDTH-1:0] rv);
      int code, lat, lat_exp, base;
      code = 0;
      if (c == 2'd3) code = 5;
      else if (c == 2'd0 && ref_saved.size() == MAXF) code = 2;
      else if (c == 2'd0 && ref_stk.size() < ref_limit + n) code = 1;
      else if (c != 2'd0 && ref_saved.size() == 0) code = 3;
      usr_op = OpNone; cmd_valid = 1'b1; cmd = c; nargs = (DEPTH+1)'(n); ret_val = rv;
      #1;
      check_eq("cmd_ready", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0; ret_val = ~rv;
      lat = 1;
      while (done !== 1'b1 && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      lat_exp = 1;
      if (code == 0 && c == 2'd0) begin
         ref_saved.push_back(ref_limit);
         ref_limit = ref_stk.size() - n;
         lat_exp = 2;
      end else if (code == 0) begin
         base = ref_limit;
         if (c == 2'd2 && base == SMAX) code = 4;
         else begin
            while (ref_stk.size() > base) void'(ref_stk.pop_back());
            if (c == 2'd2) ref_stk.push_back(rv);
         end
         ref_limit = ref_saved.pop_back();
         lat_exp = 4;
      end
      check_eq("latency", lat, lat_exp);
      check_eq("err", err, code != 0);
      check_eq("err_code", err_code, code);
      check_eq("frame_level", frame_level, ref_saved.size());
      check_eq("limit", stk_underflow_limit, ref_limit);
      check_eq("index", stk_index, ref_stk.size());
      if (code == 0) check_eq("status", stk_status, exp_status(ref_stk.size(), ref_limit));
      if (ref_stk.size() > 0) check_eq("tos", s_mem[4'(s_idx - 1'b1)], ref_stk[ref_stk.size()-1]);
      @(posedge clk); #1;
      check_eq("done_pulse", done, 0);
      check_eq("err_code_held", err_code, code);
   endtask

   initial begin
      do_reset();
      check_eq("rst_ready", usr_ready, 1);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_err_code", err_code, 0);
      check_eq("rst_level", frame_level, 0);
      check_eq("rst_limit", stk_underflow_limit, 0);
      check_eq("rst_stk_op", stk_op, OpNone);

      // Plan 1 and 2
      host_op(OpPush, 8'd10); host_op(OpPush, 8'd20); host_op(OpPush, 8'd30);
      do_cmd(2'd0, 2, 8'd0);
      check_eq("t1_limit", stk_underflow_limit, 1);
      check_eq("t1_status", stk_status, StNone);
      host_op(OpPush, 8'd40);
      do_cmd(2'd2, 0, 8'd99);
      check_eq("t2_index", stk_index, 2);
      check_eq("t2_tos", s_mem[1], 99);

      // Plan 3
      do_reset();
      host_op(OpPush, 8'd10); host_op(OpPush, 8'd20); host_op(OpPush, 8'd30);
      do_cmd(2'd0, 2, 8'd0);
      do_cmd(2'd1, 0, 8'd0);
      check_eq("t3_tos", s_mem[0], 10);

      // Plan 4: frame overflow then unwind to underflow
      do_reset();
      for (int i = 0; i < MAXF + 1; i++) do_cmd(2'd0, 0, 8'd0);
      check_eq("t4_level", frame_level, MAXF);
      for (int i = 0; i < MAXF + 1; i++) do_cmd(2'd1, 0, 8'd0);

      // Plan 5: argument shortage and reserved command
      do_reset();
      host_op(OpPush, 8'd5);
      do_cmd(2'd0, 3, 8'd0);
      do_cmd(2'd3, 0, 8'd0);

      // Return value into a full stack reports a stack error but still pops the frame
      do_reset();
      for (int i = 0; i < SMAX; i++) host_op(OpPush, 8'(i + 1));
      do_cmd(2'd0, 0, 8'd0);
      do_cmd(2'd2, 0, 8'd77);

      // Plan 6: host priority, then reset in DROP
      do_reset();
      host_op(OpPush, 8'd1);
      do_cmd(2'd0, 1, 8'd0);
      usr_op = OpPush; usr_data = 8'd2; cmd_valid = 1'b1; cmd = 2'd1;
      #1 check_eq("t6_block", cmd_ready, 0);
      usr_op = OpNone;
      #1 check_eq("t6_unblock", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check_eq("t6_drop_op", stk_op, OpUReset);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_eq("t6_rst_ready", usr_ready, 1);
      check_eq("t6_rst_limit", stk_underflow_limit, 0);
      check_eq("t6_rst_level", frame_level, 0);
      check_eq("t6_rst_done", done, 0);

      // Randomized traffic
      do_reset();
      for (int it = 0; it < 400; it++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 55) begin
            int k;
            k = $urandom_range(0, 2);
            if (k == 0 && ref_stk.size() < SMAX) host_op(OpPush, 8'($urandom));
            else if (k == 1 && ref_stk.size() > ref_limit) host_op(OpPop, 8'd0);
            else host_op(OpNone, 8'd0);
         end else begin
            int c;
            r = $urandom_range(0, 99);
            c = (r < 40) ? 0 : (r < 65) ? 1 : (r < 92) ? 2 : 3;
            do_cmd(2'(c), $urandom_range(0, 3), 8'($urandom));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
